// File: rtl/shader_fetch_if.sv
// shader_fetch_if
// Groups the program-load port, the run-control port and the execute-stage
// port of shader_fetch into one bundle.
//   master : the side that loads programs and starts runs (host / bench)
//   slave  : shader_fetch itself
// Signals:
//   load_start_i  rewind write pointer to slot 0 (one-cycle pulse)
//   load_valid_i  program byte offered on load_data_i
//   load_data_i   instruction byte to store
//   load_ready_o  program memory accepts a byte this cycle
//   start_i       begin running the program for one pixel
//   busy_o        a program run is in progress
//   instr_o       instruction to the execute stage
//   execute_o     instr_o is valid and executed this cycle
//   done_o        one-cycle pulse after a run completes
interface shader_fetch_if;
    logic       load_start_i;
    logic       load_valid_i;
    logic [7:0] load_data_i;
    logic       load_ready_o;
    logic       start_i;
    logic       busy_o;
    logic [7:0] instr_o;
    logic       execute_o;
    logic       done_o;

    modport master (
        output load_start_i, load_valid_i, load_data_i, start_i,
        input  load_ready_o, busy_o, instr_o, execute_o, done_o
    );

    modport slave (
        input  load_start_i, load_valid_i, load_data_i, start_i,
        output load_ready_o, busy_o, instr_o, execute_o, done_o
    );
endinterface

// File: rtl/shader_fetch.sv
// shader_fetch
// Small program store plus sequencer for a per-pixel shader. While idle,
// bytes are written into NUM_INSTR flop slots through a write pointer; a
// start launches a run that presents every slot in order to the execute
// stage, one per cycle, followed by a single-cycle done pulse.
// Ports:
//   clk_i   clock, all state updates on its rising edge
//   rst_ni  asynchronous active-low reset
//   bus     shader_fetch_if.slave (load, run control and execute signals)
module shader_fetch #(
    parameter int         NUM_INSTR = 16,
    parameter logic [7:0] NOP_INSTR = 8'h40
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    shader_fetch_if.slave bus
);

    localparam int            AW      = $clog2(NUM_INSTR);
    localparam logic [AW-1:0] LAST_PC = AW'(NUM_INSTR - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   pc_reg, pc_next;
    logic [AW-1:0]   wptr_reg, wptr_next;
    logic            done_reg, done_next;
    logic [AW-1:0]   waddr;
    logic            wr_en;
    logic [NUM_INSTR-1:0] slot_we;
    logic [7:0]      slot_reg [NUM_INSTR];

    // Next-state logic. Loading only happens in IDLE, so a byte written on
    // the same edge that starts a run is already in place for slot 0.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        wptr_next  = wptr_reg;
        done_next  = 1'b0;
        wr_en      = 1'b0;
        waddr      = wptr_reg;
        case (state_reg)
            IDLE: begin
                // A rewind that coincides with a byte sends that byte to slot 0.
                if (bus.load_start_i) begin
                    waddr = '0;
                end
                if (bus.load_valid_i) begin
                    wr_en     = 1'b1;
                    wptr_next = waddr + 1'b1;   // wraps naturally (power of two)
                end else if (bus.load_start_i) begin
                    wptr_next = '0;
                end
                if (bus.start_i) begin
                    state_next = RUN;
                    pc_next    = '0;
                end
            end
            RUN: begin
                pc_next = pc_reg + 1'b1;
                if (pc_reg == LAST_PC) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            wptr_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            wptr_reg  <= wptr_next;
            done_reg  <= done_next;
        end
    end

    // Per-slot write enables decoded from the write address.
    for (genvar gi = 0; gi < NUM_INSTR; gi++) begin : g_slot_we
        assign slot_we[gi] = wr_en && (waddr == AW'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_INSTR; i++) begin
                slot_reg[i] <= NOP_INSTR;
            end
        end else begin
            for (int i = 0; i < NUM_INSTR; i++) begin
                if (slot_we[i]) begin
                    slot_reg[i] <= bus.load_data_i;
                end
            end
        end
    end

    assign bus.load_ready_o = (state_reg == IDLE);
    assign bus.busy_o       = (state_reg == RUN);
    assign bus.execute_o    = (state_reg == RUN);
    // Read straight from the slot flops so the current contents are issued.
    assign bus.instr_o      = (state_reg == RUN) ? slot_reg[pc_reg] : NOP_INSTR;
    assign bus.done_o       = done_reg;

endmodule

// File: tb/tb_shader_fetch.sv
// tb_shader_fetch
// Directed bench for shader_fetch. Stimulus pushes the expected instruction
// stream into a queue before each run; a monitor on the falling clock edge
// pops and compares every executed instruction and checks the busy, ready,
// idle-instruction and done behaviour cycle by cycle.
module tb_shader_fetch;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    shader_fetch_if sf_bus ();

    shader_fetch #(
        .NUM_INSTR (16),
        .NOP_INSTR (8'h40)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (sf_bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   run_len   = 0;
    logic prev_exec = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            run_len   = 0;
            prev_exec = 1'b0;
        end else begin
            chk("busy_eq_exec", {31'd0, sf_bus.busy_o}, {31'd0, sf_bus.execute_o});
            chk("ready_not_busy", {31'd0, sf_bus.load_ready_o}, {31'd0, !sf_bus.execute_o});
            if (sf_bus.execute_o === 1'b1) begin
                run_len++;
                chk("run_len_le_16", {31'd0, run_len <= 16}, 32'd1);
                chk("done_during_exec", {31'd0, sf_bus.done_o}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_exec", 32'd1, 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    $display("txn exec instr=%02h expected=%02h", sf_bus.instr_o, e);
                    chk("instr", {24'd0, sf_bus.instr_o}, {24'd0, e});
                end
            end else begin
                chk("idle_instr", {24'd0, sf_bus.instr_o}, 32'h40);
                chk("done", {31'd0, sf_bus.done_o}, {31'd0, prev_exec && (run_len == 16)});
                run_len = 0;
            end
            prev_exec = sf_bus.execute_o;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic rewind);
        sf_bus.load_valid_i = 1'b1;
        sf_bus.load_start_i = rewind;
        sf_bus.load_data_i  = d;
        tick();
        sf_bus.load_valid_i = 1'b0;
        sf_bus.load_start_i = 1'b0;
    endtask

    task automatic start_run();
        sf_bus.start_i = 1'b1;
        tick();
        sf_bus.start_i = 1'b0;
    endtask

    // Wait for the run to end, then step past the done cycle.
    task automatic wait_idle();
        int n = 0;
        while (sf_bus.busy_o === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("run_end_timeout", {31'd0, sf_bus.busy_o}, 32'd0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_exec"},  {31'd0, sf_bus.execute_o},    32'd0);
        chk({tag, "_busy"},  {31'd0, sf_bus.busy_o},       32'd0);
        chk({tag, "_done"},  {31'd0, sf_bus.done_o},       32'd0);
        chk({tag, "_ready"}, {31'd0, sf_bus.load_ready_o}, 32'd1);
        chk({tag, "_instr"}, {24'd0, sf_bus.instr_o},      32'h40);
    endtask

    task automatic push_nops();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h40);
    endtask

    task automatic push_prog_a5();
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      exp_q.push_back(8'hA5);
            else if (i == 1) exp_q.push_back(8'hA6);
            else             exp_q.push_back(8'hC0 + 8'(i));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sf_bus.load_start_i = 1'b0;
        sf_bus.load_valid_i = 1'b0;
        sf_bus.load_data_i  = 8'h00;
        sf_bus.start_i      = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("reset");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Empty program runs NOPs.
        push_nops();
        start_run();
        wait_idle();

        // 17 bytes without rewind: byte 0x10 wraps onto slot 0.
        for (int i = 0; i <= 16; i++) load_byte(8'(i), 1'b0);
        for (int i = 0; i < 16; i++) exp_q.push_back(i == 0 ? 8'h10 : 8'(i));
        start_run();
        wait_idle();

        // Rewind pulse alone (wptr was 1), then C0..CF.
        sf_bus.load_start_i = 1'b1;
        tick();
        sf_bus.load_start_i = 1'b0;
        for (int i = 0; i < 16; i++) load_byte(8'hC0 + 8'(i), 1'b0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hC0 + 8'(i));
        start_run();
        wait_idle();

        // Rewind coinciding with a byte, then a byte on the same edge as start.
        load_byte(8'hA5, 1'b1);
        push_prog_a5();
        sf_bus.load_valid_i = 1'b1;
        sf_bus.load_data_i  = 8'hA6;
        start_run();
        // Bytes and rewinds offered during the run must be dropped.
        sf_bus.load_valid_i = 1'b1;
        sf_bus.load_data_i  = 8'hFF;
        sf_bus.load_start_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            chk("ready_in_run", {31'd0, sf_bus.load_ready_o}, 32'd0);
            tick();
        end
        sf_bus.load_valid_i = 1'b0;
        sf_bus.load_start_i = 1'b0;
        wait_idle();

        // Rerun shows the program unchanged.
        push_prog_a5();
        start_run();
        wait_idle();

        // start_i held high: three bursts with one idle cycle between.
        push_prog_a5();
        push_prog_a5();
        push_prog_a5();
        sf_bus.start_i = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) begin
            chk("b2b_exec", {31'd0, sf_bus.execute_o}, {31'd0, !(i == 16 || i == 33)});
            if (i == 40) sf_bus.start_i = 1'b0;
            tick();
        end
        chk("b2b_end_exec", {31'd0, sf_bus.execute_o}, 32'd0);
        chk("b2b_end_done", {31'd0, sf_bus.done_o}, 32'd1);
        tick();

        // Reset during the 5th execute cycle.
        push_prog_a5();
        start_run();
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset_exec", {31'd0, sf_bus.execute_o}, 32'd1);
        rst_ni = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        exp_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_reset_done", {31'd0, sf_bus.done_o}, 32'd0);
        push_nops();
        start_run();
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shader_fetch.md
SHADER_FETCH -- requirements
Module: shader_fetch

Interface
REQ-001 SHALL have parameter NUM_INSTR, default 16, number of program slots (power of two, 2..64).
REQ-002 SHALL have parameter NOP_INSTR, default 8'h40, instruction with no architectural effect (AND R0,R0).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port load_start_i  input  1  one-cycle pulse that rewinds the write pointer to slot 0.
REQ-006 SHALL have port load_valid_i  input  1  a program byte is offered on load_data_i.
REQ-007 SHALL have port load_data_i  input  8  instruction byte to store.
REQ-008 SHALL have port load_ready_o  output  1  program memory accepts a byte this cycle.
REQ-009 SHALL have port start_i  input  1  begin running the program for one pixel.
REQ-010 SHALL have port busy_o  output  1  a program run is in progress.
REQ-011 SHALL have port instr_o  output  8  instruction to the execute stage.
REQ-012 SHALL have port execute_o  output  1  instr_o is valid and is executed this cycle.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse when a run has completed.

Function
REQ-014 SHALL hold NUM_INSTR x 8-bit program slots in flops and a write pointer wptr of width log2(NUM_INSTR).
REQ-015 SHALL implement states IDLE and RUN, with a program counter pc of width log2(NUM_INSTR).
REQ-016 SHALL drive load_ready_o = 1 in IDLE and 0 in RUN.
REQ-017 SHALL store load_data_i into slot wptr and increment wptr modulo NUM_INSTR (wrap to 0 after NUM_INSTR-1) when load_valid_i and load_ready_o are both high.
REQ-018 SHALL set wptr to 0 on load_start_i when no byte is accepted in that cycle.
REQ-019 SHALL, when load_start_i coincides with an accepted byte, write that byte to slot 0 and set wptr to 1.
REQ-020 SHALL ignore load_valid_i and load_start_i in RUN: no write, no wptr change, and bytes offered in RUN are dropped.
REQ-021 SHALL, when start_i is sampled high in IDLE, move to RUN with pc = 0 at that edge.
REQ-022 SHALL ignore start_i in RUN.
REQ-023 SHALL, in RUN, drive execute_o = 1 and instr_o = slot[pc] combinationally from the current slot contents, and increment pc every cycle.
REQ-024 SHALL hold execute_o high for exactly NUM_INSTR consecutive cycles per run, with slots 0..NUM_INSTR-1 presented in order.
REQ-025 SHALL return to IDLE after the cycle in which pc = NUM_INSTR-1, and drive done_o high for exactly the one following cycle (registered).
REQ-026 SHALL drive busy_o high exactly in RUN.
REQ-027 SHALL drive execute_o = 0 and instr_o = NOP_INSTR in IDLE.
REQ-028 SHALL make a write accepted on the same edge as a start visible to the run that edge starts, so a new slot 0 is issued in the first RUN cycle.
REQ-029 SHALL accept start_i during the done_o cycle, giving back-to-back runs separated by exactly one non-execute cycle.

Reset
REQ-030 SHALL, on rst_ni low and independent of clk_i, force state IDLE, pc = 0, wptr = 0, every slot = NOP_INSTR, execute_o = 0, done_o = 0, busy_o = 0, load_ready_o = 1, instr_o = NOP_INSTR.
REQ-031 SHALL abort any run when reset is asserted mid-run, with no done_o pulse, and SHALL resume normal operation on the first clock edge after rst_ni rises.

Verification
REQ-032 Scenario: after reset, pulse start_i -> 16 cycles of execute_o = 1 with instr_o = 8'h40, then done_o high for 1 cycle; busy_o high for exactly those 16 cycles.
REQ-033 Scenario: load_start_i, then load bytes 8'hC0..8'hCF, then start_i -> instr_o sequence 8'hC0, 8'hC1, ... 8'hCF over 16 consecutive cycles.
REQ-034 Scenario: load 17 bytes 8'h00..8'h10 without load_start_i -> slot 0 = 8'h10, slot 1 = 8'h01 (wptr wrap).
REQ-035 Scenario: load_valid_i held high with 8'hFF throughout a run -> load_ready_o = 0 for the whole run, and a rerun shows unchanged program contents.
REQ-036 Scenario: start_i held high continuously -> runs repeat with one idle cycle (done_o = 1, execute_o = 0) between each 16-cycle burst.
REQ-037 Scenario: rst_ni pulsed low at the 5th execute cycle -> outputs take reset values immediately, no done_o, and all slots read back as 8'h40 on the next run.
